sap_control_sequencer: RTL and testbench

//  Controller for the 8-bit SAP datapath: steps a T-state counter, decodes the IR opcode, drives
//  all bus load/enable strobes, and is the initiator for the ALU (Operation/AluStart/ALUOut).

---
 rtl/sap_control_sequencer.sv | 131 +++++++++++++
 tb/tb_sap_control_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sap_control_sequencer.sv
// SAP controller: T-state sequencer with opcode decode into bus strobes, ALU control and flag latch.
// Bus protocol: every strobe is level-sensitive for one T-state and acts on the rising Clk edge that ends it.
module sap_control_sequencer #(
  parameter int OPCODE_W = 4,
  parameter int T_LAST   = 5,
  localparam int SW      = $clog2(T_LAST + 1)
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic [1:0]          Flags,
  output logic                PcOut,
  output logic                PcInc,
  output logic                PcLoad,
  output logic                MarLoad,
  output logic                RamOut,
  output logic                RamLoad,
  output logic                IrLoad,
  output logic                IrOut,
  output logic                ALoad,
  output logic                BLoad,
  output logic                OutLoad,
  output logic                AOut,
  output logic [1:0]          Operation,
  output logic                AluStart,
  output logic                ALUOut,
  output logic [1:0]          FlagReg,
  output logic                Halted,
  output logic [SW-1:0]       State
);

  typedef enum logic [SW-1:0] {
    S_RST = SW'(0),
    S_T1  = SW'(1),
    S_T2  = SW'(2),
    S_T3  = SW'(3),
    S_T4  = SW'(4),
    S_T5  = SW'(5)
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_INC = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_DCR = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(15);

  state_t state, state_nx;
  logic   halt_set;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_RST;
      FlagReg <= 2'b00;
      Halted  <= 1'b0;
    end else begin
      state <= state_nx;
      if (AluStart) FlagReg <= Flags;
      if (halt_set) Halted <= 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    halt_set  = 1'b0;
    PcOut     = 1'b0;
    PcInc     = 1'b0;
    PcLoad    = 1'b0;
    MarLoad   = 1'b0;
    RamOut    = 1'b0;
    RamLoad   = 1'b0;
    IrLoad    = 1'b0;
    IrOut     = 1'b0;
    ALoad     = 1'b0;
    BLoad     = 1'b0;
    OutLoad   = 1'b0;
    AOut      = 1'b0;
    Operation = 2'b00;
    AluStart  = 1'b0;
    ALUOut    = 1'b0;
    if (!Halted) begin
      if (state == S_RST || state == state_t'(SW'(T_LAST))) state_nx = S_T1;
      else state_nx = state_t'(SW'(state) + SW'(1));
      case (state)
        S_T1: begin PcOut = 1'b1; MarLoad = 1'b1; end
        S_T2: begin RamOut = 1'b1; IrLoad = 1'b1; PcInc = 1'b1; end
        S_T3: begin
          case (Opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin IrOut = 1'b1; MarLoad = 1'b1; end
            OP_INC: begin Operation = 2'b10; AluStart = 1'b1; ALUOut = 1'b1; ALoad = 1'b1; end
            OP_DCR: begin Operation = 2'b11; AluStart = 1'b1; ALUOut = 1'b1; ALoad = 1'b1; end
            OP_LDI: begin IrOut = 1'b1; ALoad = 1'b1; end
            OP_JMP: begin IrOut = 1'b1; PcLoad = 1'b1; end
            // Conditional jumps look at the latched flags, never the live ALU outputs.
            OP_JC:  begin IrOut = 1'b1; PcLoad = FlagReg[0]; end
            OP_JZ:  begin IrOut = 1'b1; PcLoad = FlagReg[1]; end
            OP_OUT: begin AOut = 1'b1; OutLoad = 1'b1; end
            OP_HLT: begin halt_set = 1'b1; state_nx = state; end
            default: ;
          endcase
        end
        S_T4: begin
          case (Opcode)
            OP_LDA:         begin RamOut = 1'b1; ALoad = 1'b1; end
            OP_ADD, OP_SUB: begin RamOut = 1'b1; BLoad = 1'b1; end
            OP_STA:         begin AOut = 1'b1; RamLoad = 1'b1; end
            default: ;
          endcase
        end
        S_T5: begin
          if (Opcode == OP_ADD || Opcode == OP_SUB) begin
            Operation = (Opcode == OP_SUB) ? 2'b01 : 2'b00;
            AluStart  = 1'b1;
            ALUOut    = 1'b1;
            ALoad     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign State = SW'(state);

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Randomized scoreboard bench for sap_control_sequencer against a T-state/opcode table model.
module tb_sap_control_sequencer;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [3:0] Opcode = 4'd0;
  logic [1:0] Flags = 2'b00;
  logic PcOut, PcInc, PcLoad, MarLoad, RamOut, RamLoad, IrLoad, IrOut;
  logic ALoad, BLoad, OutLoad, AOut, AluStart, ALUOut, Halted;
  logic [1:0] Operation, FlagReg;
  logic [2:0] State;

  sap_control_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n), .Opcode(Opcode), .Flags(Flags),
    .PcOut(PcOut), .PcInc(PcInc), .PcLoad(PcLoad), .MarLoad(MarLoad),
    .RamOut(RamOut), .RamLoad(RamLoad), .IrLoad(IrLoad), .IrOut(IrOut),
    .ALoad(ALoad), .BLoad(BLoad), .OutLoad(OutLoad), .AOut(AOut),
    .Operation(Operation), .AluStart(AluStart), .ALUOut(ALUOut),
    .FlagReg(FlagReg), .Halted(Halted), .State(State)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load, ir_load, ir_out;
    logic a_load, b_load, out_load, a_out;
    logic [1:0] op;
    logic alu_start, alu_out;
  } ctrl_t;

  // Observed word: {controls, FlagReg, Halted, State}
  logic [21:0] obs;
  assign obs = {PcOut, PcInc, PcLoad, MarLoad, RamOut, RamLoad, IrLoad, IrOut,
                ALoad, BLoad, OutLoad, AOut, Operation, AluStart, ALUOut,
                FlagReg, Halted, State};

  logic [21:0] exp_q[$];
  int  pass_cnt = 0;
  int  total_cnt = 0;
  bit  mon_en = 1'b0;

  int         m_t;
  logic [1:0] m_fr;
  bit         m_halt;

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic ctrl_t model_ctrl(input int t, input logic [3:0] op,
                                       input logic [1:0] fr, input bit halt);
    ctrl_t c;
    c = '0;
    if (halt) return c;
    if (t == 1) begin c.pc_out = 1; c.mar_load = 1; end
    else if (t == 2) begin c.ram_out = 1; c.ir_load = 1; c.pc_inc = 1; end
    else if (t >= 3) begin
      case (op)
        4'd0: if (t == 3) begin c.ir_out = 1; c.mar_load = 1; end
              else if (t == 4) begin c.ram_out = 1; c.a_load = 1; end
        4'd1, 4'd2: if (t == 3) begin c.ir_out = 1; c.mar_load = 1; end
              else if (t == 4) begin c.ram_out = 1; c.b_load = 1; end
              else if (t == 5) begin
                c.op = (op == 4'd2) ? 2'b01 : 2'b00;
                c.alu_start = 1; c.alu_out = 1; c.a_load = 1;
              end
        4'd3: if (t == 3) begin c.op = 2'b10; c.alu_start = 1; c.alu_out = 1; c.a_load = 1; end
        4'd4: if (t == 3) begin c.op = 2'b11; c.alu_start = 1; c.alu_out = 1; c.a_load = 1; end
        4'd5: if (t == 3) begin c.ir_out = 1; c.mar_load = 1; end
              else if (t == 4) begin c.a_out = 1; c.ram_load = 1; end
        4'd6: if (t == 3) begin c.ir_out = 1; c.a_load = 1; end
        4'd7: if (t == 3) begin c.ir_out = 1; c.pc_load = 1; end
        4'd8: if (t == 3) begin c.ir_out = 1; c.pc_load = fr[0]; end
        4'd9: if (t == 3) begin c.ir_out = 1; c.pc_load = fr[1]; end
        4'd14: if (t == 3) begin c.a_out = 1; c.out_load = 1; end
        default: ;
      endcase
    end
    return c;
  endfunction

  // Called at posedge+1: drive one T-state, queue its expectation, advance the model.
  task automatic drive_cycle(input logic [3:0] op, input logic [1:0] fl);
    ctrl_t c;
    Opcode = op;
    Flags  = fl;
    c = model_ctrl(m_t, op, m_fr, m_halt);
    exp_q.push_back({c, m_fr, m_halt, 3'(m_t)});
    @(posedge Clk);
    if (c.alu_start) m_fr = fl;
    if (!m_halt) begin
      if (m_t == 3 && op == 4'd15) m_halt = 1'b1;
      else m_t = (m_t == 0 || m_t == 5) ? 1 : m_t + 1;
    end
    #1;
  endtask

  task automatic run_instr(input logic [3:0] op, input int n, input logic [1:0] t5_flags);
    for (int i = 0; i < n; i++)
      drive_cycle(op, (i == 4) ? t5_flags : 2'($urandom_range(0, 3)));
  endtask

  task automatic apply_reset();
    mon_en = 1'b0;
    exp_q.delete();
    Reset_n = 1'b0;
    #1;
    check("reset_async", obs, 22'd0);
    @(posedge Clk);
    #1;
    check("reset_hold", obs, 22'd0);
    Reset_n = 1'b1;
    m_t = 0; m_fr = 2'b00; m_halt = 1'b0;
    mon_en = 1'b1;
  endtask

  always @(negedge Clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL no_expectation: got %h expected queued entry at %0t", obs, $time);
      end else begin
        check("ctrl_word", obs, exp_q.pop_front());
      end
      check("bus_drivers", 22'(int'(PcOut) + int'(RamOut) + int'(IrOut) + int'(AOut) + int'(ALUOut) <= 1),
            22'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ctrl_t c;
    apply_reset();
    drive_cycle(4'd0, 2'b00);              // S_RST cycle
    run_instr(4'd1, 5, 2'b11);             // ADD, flags 11 captured in T5
    check("flagreg_after_add", {20'd0, FlagReg}, 22'b11);
    run_instr(4'd2, 5, 2'b10);             // SUB leaves FlagReg=10
    run_instr(4'd9, 5, 2'b01);             // JZ taken
    run_instr(4'd8, 5, 2'b11);             // JC not taken, live Flags ignored
    run_instr(4'd4, 5, 2'b00);             // DCR
    for (int i = 0; i < 120; i++)
      run_instr(4'($urandom_range(0, 14)), 5, 2'($urandom_range(0, 3)));

    // Abort ADD in T4 with an asynchronous reset.
    run_instr(4'd1, 5, 2'b11);
    run_instr(4'd1, 3, 2'b00);
    mon_en = 1'b0;
    #2;
    c = model_ctrl(4, 4'd1, m_fr, 1'b0);
    check("add_t4_before_abort", obs, {c, 2'b11, 1'b0, 3'd4});
    apply_reset();
    drive_cycle(4'd6, 2'b00);
    for (int i = 0; i < 20; i++)
      run_instr(4'($urandom_range(0, 14)), 5, 2'($urandom_range(0, 3)));

    run_instr(4'd15, 5, 2'b00);            // HLT
    for (int i = 0; i < 10; i++)
      drive_cycle(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    check("halted_flag", {21'd0, Halted}, 22'd1);
    @(negedge Clk);
    mon_en = 1'b0;
    check("queue_drained", 22'(exp_q.size()), 22'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
